// File: rtl/if_stage_pkg.sv
// Shared core definitions for the instruction-fetch stage: bubble encoding,
// default reset vector, the IF/ID pipeline record and small address helpers.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'd0,
        PC_HOLD     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_CAPTURE = 2'd0,
        IFID_HOLD    = 2'd1,
        IFID_BUBBLE  = 2'd2
    } ifid_op_e;

    // Clears the byte-offset bits; all bits of the argument are read.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

    // Sequential successor address, wrapping naturally at 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// slave = the fetch stage itself, master = the surrounding core / environment.
interface if_stage_if;

    logic        stall_i;
    logic        flush_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;

    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;

    logic [31:0] pc_debug_o;
    logic [31:0] fetch_count_o;

    modport slave (
        input  stall_i,
        input  flush_i,
        input  redirect_valid_i,
        input  redirect_pc_i,
        input  imem_rdata_i,
        output imem_addr_o,
        output if_id_pc_o,
        output if_id_pc4_o,
        output if_id_instr_o,
        output if_id_valid_o,
        output pc_debug_o,
        output fetch_count_o
    );

    modport master (
        output stall_i,
        output flush_i,
        output redirect_valid_i,
        output redirect_pc_i,
        output imem_rdata_i,
        input  imem_addr_o,
        input  if_id_pc_o,
        input  if_id_pc4_o,
        input  if_id_instr_o,
        input  if_id_valid_o,
        input  pc_debug_o,
        input  fetch_count_o
    );

endinterface

// File: rtl/if_stage_pc_gen.sv
// Program-counter register and next-PC selection.
// Redirect outranks stall; otherwise the PC steps by one word.
module pc_gen #(
    parameter logic [31:0] RESET_PC = if_stage_pkg::DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);
    import if_stage_pkg::*;

    logic [31:0] pc_r;
    logic [31:0] pc4_s;
    logic [31:0] pc_next_s;
    pc_sel_e     pc_sel_s;

    assign pc4_s = next_seq_pc(pc_r);

    // Source selection for the next PC.
    always_comb begin
        pc_sel_s = PC_SEQ;
        if (redirect_valid_i) begin
            pc_sel_s = PC_REDIRECT;
        end else if (stall_i) begin
            pc_sel_s = PC_HOLD;
        end else begin
            pc_sel_s = PC_SEQ;
        end
    end

    // Next-PC multiplexer; a redirect target loses its byte offset.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_SEQ:      pc_next_s = pc4_s;
            PC_HOLD:     pc_next_s = pc_r;
            PC_REDIRECT: pc_next_s = word_align(redirect_pc_i);
            default:     pc_next_s = pc_r;
        endcase
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc_o  = pc_r;
    assign pc4_o = pc4_s;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction memory from the PC and
// registers the fetched word into IF/ID, inserting bubbles on flush/redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC  = if_stage_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    if_stage_if.slave bus
);
    import if_stage_pkg::*;

    logic [31:0] pc_s;
    logic [31:0] pc4_s;
    ifid_op_e    ifid_op_s;
    if_id_t      if_id_next_s;
    if_id_t      if_id_r;
    logic [31:0] fetch_count_r;

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (bus.stall_i),
        .redirect_valid_i (bus.redirect_valid_i),
        .redirect_pc_i    (bus.redirect_pc_i),
        .pc_o             (pc_s),
        .pc4_o            (pc4_s)
    );

    // IF/ID action: a redirect kills the wrong-path fetch even under stall.
    always_comb begin
        ifid_op_s = IFID_CAPTURE;
        if (bus.flush_i || bus.redirect_valid_i) begin
            ifid_op_s = IFID_BUBBLE;
        end else if (bus.stall_i) begin
            ifid_op_s = IFID_HOLD;
        end else begin
            ifid_op_s = IFID_CAPTURE;
        end
    end

    // Next IF/ID contents; bubbles still record the current pc/pc4.
    always_comb begin
        if_id_next_s = if_id_r;
        case (ifid_op_s)
            IFID_CAPTURE: begin
                if_id_next_s.pc    = pc_s;
                if_id_next_s.pc4   = pc4_s;
                if_id_next_s.instr = bus.imem_rdata_i;
                if_id_next_s.valid = 1'b1;
            end
            IFID_BUBBLE: begin
                if_id_next_s.pc    = pc_s;
                if_id_next_s.pc4   = pc4_s;
                if_id_next_s.instr = NOP_INSTR;
                if_id_next_s.valid = 1'b0;
            end
            IFID_HOLD: begin
                if_id_next_s = if_id_r;
            end
            default: begin
                if_id_next_s = if_id_r;
            end
        endcase
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_id_r.pc    <= 32'd0;
            if_id_r.pc4   <= 32'd0;
            if_id_r.instr <= NOP_INSTR;
            if_id_r.valid <= 1'b0;
        end else begin
            if_id_r <= if_id_next_s;
        end
    end

    // Count of real instructions accepted into IF/ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_count_r <= 32'd0;
        end else if (ifid_op_s == IFID_CAPTURE) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign bus.imem_addr_o   = word_align(pc_s);
    assign bus.pc_debug_o    = pc_s;
    assign bus.if_id_pc_o    = if_id_r.pc;
    assign bus.if_id_pc4_o   = if_id_r.pc4;
    assign bus.if_id_instr_o = if_id_r.instr;
    assign bus.if_id_valid_o = if_id_r.valid;
    assign bus.fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, flush,
// redirect, redirect+stall, PC wrap and asynchronous reset mid-stall.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'd0) begin
            w = 32'h0050_0093;
        end else begin
            w = {a[31:2] ^ 30'h2AAA_5555, 2'b11};
        end
        return w;
    endfunction

    assign bus.imem_rdata_i = imem(bus.imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc_exp,
                             input logic [31:0] ifpc, input logic [31:0] instr,
                             input logic valid, input logic [31:0] cnt);
        chk({tag, ".pc_debug"}, bus.pc_debug_o, pc_exp);
        chk({tag, ".imem_addr"}, bus.imem_addr_o, pc_exp);
        chk({tag, ".if_id_pc"}, bus.if_id_pc_o, ifpc);
        chk({tag, ".if_id_pc4"}, bus.if_id_pc4_o, ifpc + 32'd4);
        chk({tag, ".if_id_instr"}, bus.if_id_instr_o, instr);
        chk({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid_o}, {31'd0, valid});
        chk({tag, ".fetch_count"}, bus.fetch_count_o, cnt);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc_debug"}, bus.pc_debug_o, 32'd0);
        chk({tag, ".imem_addr"}, bus.imem_addr_o, 32'd0);
        chk({tag, ".if_id_pc"}, bus.if_id_pc_o, 32'd0);
        chk({tag, ".if_id_pc4"}, bus.if_id_pc4_o, 32'd0);
        chk({tag, ".if_id_instr"}, bus.if_id_instr_o, NOP);
        chk({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid_o}, 32'd0);
        chk({tag, ".fetch_count"}, bus.fetch_count_o, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i = 32'd0;

        // Reset state, then release between edges.
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        tick();
        chk_state("first_fetch", 32'd4, 32'd0, 32'h0050_0093, 1'b1, 32'd1);
        tick();
        chk_state("seq4", 32'd8, 32'd4, imem(32'd4), 1'b1, 32'd2);

        // Stall three cycles at pc=8.
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("stall", 32'd8, 32'd4, imem(32'd4), 1'b1, 32'd2);
        end
        bus.stall_i = 1'b0;
        tick();
        chk_state("resume", 32'd12, 32'd8, imem(32'd8), 1'b1, 32'd3);
        tick();
        chk_state("seq12", 32'd16, 32'd12, imem(32'd12), 1'b1, 32'd4);

        // Flush alone at pc=16.
        bus.flush_i = 1'b1;
        tick();
        chk_state("flush", 32'd20, 32'd16, NOP, 1'b0, 32'd4);
        bus.flush_i = 1'b0;

        // Redirect at pc=20 to a misaligned target.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        tick();
        chk_state("redirect", 32'h100, 32'd20, NOP, 1'b0, 32'd4);
        bus.redirect_valid_i = 1'b0;
        tick();
        chk_state("redir_tgt", 32'h104, 32'h100, imem(32'h100), 1'b1, 32'd5);

        // Flush together with stall.
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        chk_state("flush_stall", 32'h104, 32'h104, NOP, 1'b0, 32'd5);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;

        // Move to pc=40, then redirect and stall together.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i = 32'd40;
        tick();
        chk_state("to40", 32'd40, 32'h104, NOP, 1'b0, 32'd5);
        bus.redirect_pc_i = 32'h80;
        bus.stall_i = 1'b1;
        tick();
        chk_state("redir_stall", 32'h80, 32'd40, NOP, 1'b0, 32'd5);
        bus.redirect_valid_i = 1'b0;
        bus.stall_i = 1'b0;
        tick();
        chk_state("after_rs", 32'h84, 32'h80, imem(32'h80), 1'b1, 32'd6);

        // PC wrap at the top of the address space.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        chk_state("to_top", 32'hFFFF_FFFC, 32'h84, NOP, 1'b0, 32'd6);
        bus.redirect_valid_i = 1'b0;
        tick();
        chk_state("wrap", 32'd0, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 1'b1, 32'd7);
        tick();
        chk_state("post_wrap", 32'd4, 32'd0, 32'h0050_0093, 1'b1, 32'd8);

        // Asynchronous reset mid-stall with a redirect pending.
        bus.stall_i = 1'b1;
        tick();
        chk_state("pre_rst", 32'd4, 32'd0, 32'h0050_0093, 1'b1, 32'd8);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i = 32'h200;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        bus.stall_i = 1'b0;
        bus.redirect_valid_i = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk_state("rst_restart", 32'd4, 32'd0, 32'h0050_0093, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
